// File: rtl/fir_stream_ctrl.sv
// Upstream control for the 3-tap FIR datapath: coefficient loading, sample FIFO and y qualification.
// Optional FIR_UNDERRUN_CNT_EN adds a saturating 8-bit count of RUN underrun cycles.
module fir_stream_ctrl #(
  parameter int OPERAND_SIZE = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  input  logic [OPERAND_SIZE-1:0] coef_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [OPERAND_SIZE-1:0] s_data,
  output logic [OPERAND_SIZE-1:0] x_out,
  output logic [OPERAND_SIZE-1:0] c0_out,
  output logic [OPERAND_SIZE-1:0] c1_out,
  output logic [OPERAND_SIZE-1:0] c2_out,
  output logic                    y_valid,
  output logic                    running,
  output logic                    underrun
`ifdef FIR_UNDERRUN_CNT_EN
  ,
  output logic [7:0]              underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t state, state_next;

  logic [OPERAND_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [OPERAND_SIZE-1:0] shadow0, shadow1;
  logic [1:0]              beat_idx;
  logic                    flush_cnt;
  logic [1:0]              warm;
  logic                    coef_fire, push, pop, fifo_empty;

  assign coef_ready = (state != FLUSH);
  assign coef_fire  = coef_valid && coef_ready;
  assign fifo_empty = (count == '0);
  assign s_ready    = (count != FULL_COUNT);
  assign push       = s_valid && s_ready;
  // A coefficient beat in RUN takes priority: the stream stops on that very edge.
  assign pop        = (state == RUN) && !coef_fire && !fifo_empty;
  assign running    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (coef_fire) state_next = LOAD;
      LOAD:    if (coef_fire && beat_idx == 2'd2) state_next = FLUSH;
      FLUSH:   if (flush_cnt) state_next = RUN;
      RUN:     if (coef_fire) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // x_out and y_valid fall back to zero every cycle unless RUN pops a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out     <= '0;
      y_valid   <= 1'b0;
      c0_out    <= '0;
      c1_out    <= '0;
      c2_out    <= '0;
      shadow0   <= '0;
      shadow1   <= '0;
      beat_idx  <= '0;
      flush_cnt <= 1'b0;
      warm      <= '0;
      underrun  <= 1'b0;
`ifdef FIR_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      x_out   <= '0;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_fire) begin
            shadow0  <= coef_data;
            beat_idx <= 2'd1;
          end
        end
        LOAD: begin
          if (coef_fire) begin
            if (beat_idx == 2'd2) begin
              c0_out    <= shadow0;
              c1_out    <= shadow1;
              c2_out    <= coef_data;
              underrun  <= 1'b0;
              flush_cnt <= 1'b0;
`ifdef FIR_UNDERRUN_CNT_EN
              underrun_cnt <= '0;
`endif
            end else begin
              shadow1  <= coef_data;
              beat_idx <= 2'd2;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          warm      <= '0;
        end
        RUN: begin
          if (coef_fire) begin
            shadow0  <= coef_data;
            beat_idx <= 2'd1;
          end else if (!fifo_empty) begin
            x_out   <= fifo_mem[rd_ptr];
            y_valid <= (warm == 2'd2);
            if (warm != 2'd2) warm <= warm + 2'd1;
          end else begin
            warm     <= '0;
            underrun <= 1'b1;
`ifdef FIR_UNDERRUN_CNT_EN
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Scoreboard bench for fir_stream_ctrl: a queue-based reference model predicts the stream, a negedge monitor checks it.
// Also covers the FIR_UNDERRUN_CNT_EN counter when that macro is defined.
module tb_fir_stream_ctrl;

  localparam int OS    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          coef_valid = 1'b0;
  logic          coef_ready;
  logic [OS-1:0] coef_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [OS-1:0] s_data = '0;
  logic [OS-1:0] x_out, c0_out, c1_out, c2_out;
  logic          y_valid, running, underrun;
`ifdef FIR_UNDERRUN_CNT_EN
  logic [7:0]    underrun_cnt;
`endif

  fir_stream_ctrl #(.OPERAND_SIZE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .x_out(x_out), .c0_out(c0_out), .c1_out(c1_out), .c2_out(c2_out),
    .y_valid(y_valid), .running(running), .underrun(underrun)
`ifdef FIR_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OS-1:0]   x;
    logic [2*OS-1:0] y;
  } exp_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  exp_t          sb_q[$];
  logic [15:0]   y_log[$];
  logic [OS-1:0] coef_pending[$];
  logic [OS-1:0] sample_pending[$];

  // Reference model state: sample queue, history since the last break, load progress.
  logic [OS-1:0] m_fifo[$];
  logic [OS-1:0] m_hist[$];
  logic [OS-1:0] m_shadow[2];
  logic [OS-1:0] m_c[3];
  int            m_beats = 0;
  int            m_flush_left = 0;
  bit            m_run = 1'b0;
  bit            m_underrun = 1'b0;
  int            m_ucnt = 0;

  logic          e_coef_ready = 1'b1;
  logic          e_s_ready = 1'b1;
  logic          e_yv = 1'b0;
  logic [OS-1:0] e_x = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete(); m_hist.delete(); sb_q.delete();
      m_shadow[0] = '0; m_shadow[1] = '0;
      m_c[0] = '0; m_c[1] = '0; m_c[2] = '0;
      m_beats = 0; m_flush_left = 0; m_run = 1'b0;
      m_underrun = 1'b0; m_ucnt = 0;
      e_coef_ready = 1'b1; e_s_ready = 1'b1; e_yv = 1'b0; e_x = '0;
    end else begin
      bit acc_c, acc_s;
      acc_c = coef_valid && (m_flush_left == 0);
      acc_s = s_valid && (m_fifo.size() < DEPTH);
      e_x  = '0;
      e_yv = 1'b0;
      if (m_run && !acc_c) begin
        if (m_fifo.size() > 0) begin
          logic [OS-1:0] x;
          x = m_fifo.pop_front();
          e_x = x;
          if (m_hist.size() == 2) begin
            int y;
            exp_t e;
            y = $signed(m_c[2]) * $signed(x) + $signed(m_c[1]) * $signed(m_hist[1])
              + $signed(m_c[0]) * $signed(m_hist[0]);
            e.x = x;
            e.y = y[15:0];
            sb_q.push_back(e);
            e_yv = 1'b1;
          end
          m_hist.push_back(x);
          if (m_hist.size() > 2) void'(m_hist.pop_front());
        end else begin
          m_hist.delete();
          m_underrun = 1'b1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
      if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) m_run = 1'b1;
      end
      if (acc_c) begin
        if (m_beats == 2) begin
          m_c[0] = m_shadow[0]; m_c[1] = m_shadow[1]; m_c[2] = coef_data;
          m_underrun = 1'b0; m_ucnt = 0; m_beats = 0;
          m_flush_left = 2;
          m_hist.delete();
        end else begin
          m_shadow[m_beats] = coef_data;
          m_beats++;
          m_run = 1'b0;
          m_hist.delete();
        end
      end
      if (acc_s) m_fifo.push_back(s_data);
      e_coef_ready = (m_flush_left == 0);
      e_s_ready    = (m_fifo.size() < DEPTH);
    end
  end

  // Monitor: emulates the filter's two delay registers on the real x_out stream.
  logic [OS-1:0] f_d1 = '0, f_d2 = '0;
  int            y_i;
  logic [15:0]   y_now;

  always @(negedge clk) begin
    checkOutput("coef_ready", coef_ready, e_coef_ready);
    checkOutput("s_ready", s_ready, e_s_ready);
    checkOutput("running", running, m_run);
    checkOutput("x_out", x_out, e_x);
    checkOutput("c0_out", c0_out, m_c[0]);
    checkOutput("c1_out", c1_out, m_c[1]);
    checkOutput("c2_out", c2_out, m_c[2]);
    checkOutput("underrun", underrun, m_underrun);
    checkOutput("y_valid", y_valid, e_yv);
`ifdef FIR_UNDERRUN_CNT_EN
    checkOutput("underrun_cnt", underrun_cnt, m_ucnt);
`endif
    y_i = $signed(c2_out) * $signed(x_out) + $signed(c1_out) * $signed(f_d1)
        + $signed(c0_out) * $signed(f_d2);
    y_now = y_i[15:0];
    if (y_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL sb_extra: got y_valid with y %0d, expected no output at %0t", y_now, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_x", x_out, e.x);
        checkOutput("sb_y", y_now, e.y);
      end
      y_log.push_back(y_now);
    end
    f_d2 = f_d1;
    f_d1 = x_out;
  end

  task automatic applyStimulus(input logic cv, input logic [OS-1:0] cd, input logic sv,
                               input logic [OS-1:0] sd, output logic c_taken, output logic s_taken);
    coef_valid = cv; coef_data = cd; s_valid = sv; s_data = sd;
    @(negedge clk);
    c_taken = cv && coef_ready;
    s_taken = sv && s_ready;
    @(posedge clk); #1;
  endtask

  // Pending coefficient/sample queues take precedence; otherwise samples are random at pct percent.
  logic [OS-1:0] cur_sample = 8'h11;
  task automatic runTraffic(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      logic cv, sv, ct, st;
      logic [OS-1:0] cd, sd;
      cv = (coef_pending.size() > 0);
      cd = cv ? coef_pending[0] : OS'($urandom);
      if (sample_pending.size() > 0) begin
        sv = 1'b1; sd = sample_pending[0];
      end else begin
        sv = ($urandom_range(99) < pct); sd = cur_sample;
      end
      applyStimulus(cv, cd, sv, sd, ct, st);
      if (ct) void'(coef_pending.pop_front());
      if (st) begin
        if (sample_pending.size() > 0) void'(sample_pending.pop_front());
        else cur_sample = OS'($urandom);
      end
    end
    coef_valid = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_x_out", x_out, 0);
    checkOutput("rst_y_valid", y_valid, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_c0", c0_out, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_coef_ready", coef_ready, 1);
    checkOutput("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;

    $display("[TB] load coefs 1,2,3 and stream 1..4");
    y_log.delete();
    coef_pending = '{8'd1, 8'd2, 8'd3};
    sample_pending = '{8'd1, 8'd2, 8'd3, 8'd4};
    runTraffic(14, 0);
    checkOutput("load_c0", c0_out, 1);
    checkOutput("load_c1", c1_out, 2);
    checkOutput("load_c2", c2_out, 3);
    checkOutput("load_ycount", y_log.size(), 2);
    if (y_log.size() == 2) begin
      checkOutput("load_y0", y_log[0], 14);
      checkOutput("load_y1", y_log[1], 20);
    end

    $display("[TB] underrun gap");
    y_log.delete();
    sample_pending = '{8'd5, 8'd5, 8'd5};
    runTraffic(3, 0);
    runTraffic(1, 0);
    sample_pending = '{8'd5, 8'd5, 8'd5};
    runTraffic(7, 0);
    checkOutput("gap_ycount", y_log.size(), 2);
    if (y_log.size() == 2) begin
      checkOutput("gap_y0", y_log[0], 30);
      checkOutput("gap_y1", y_log[1], 30);
    end
    checkOutput("gap_underrun", underrun, 1);

    $display("[TB] backpressure in LOAD");
    coef_pending = '{8'd1};
    sample_pending = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    runTraffic(8, 0);
    checkOutput("bp_left", sample_pending.size(), 2);
    checkOutput("bp_s_ready", s_ready, 0);
    coef_pending = '{8'd2, 8'd3};
    runTraffic(20, 0);

    $display("[TB] reload 2,0,1 while streaming");
    runTraffic(10, 90);
    coef_pending = '{8'd2, 8'd0, 8'd1};
    runTraffic(40, 90);
    checkOutput("reload_c0", c0_out, 2);
    checkOutput("reload_c1", c1_out, 0);
    checkOutput("reload_c2", c2_out, 1);

    $display("[TB] reset mid-LOAD");
    coef_pending = '{8'd7, 8'd8, 8'd9};
    runTraffic(2, 0);
    #3 rst_n = 1'b0;
    coef_pending.delete();
    sample_pending.delete();
    #1;
    checkOutput("mrst_x_out", x_out, 0);
    checkOutput("mrst_c2", c2_out, 0);
    checkOutput("mrst_y_valid", y_valid, 0);
    checkOutput("mrst_underrun", underrun, 0);
    checkOutput("mrst_running", running, 0);
    checkOutput("mrst_s_ready", s_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    coef_pending = '{8'd3, 8'd1, 8'd2};
    runTraffic(60, 80);
    checkOutput("mrst_c0", c0_out, 3);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 8; k++) begin
      coef_pending = '{OS'($urandom), OS'($urandom), OS'($urandom)};
      runTraffic($urandom_range(300, 50), $urandom_range(100, 30));
    end

`ifdef FIR_UNDERRUN_CNT_EN
    $display("[TB] underrun counter saturation");
    runTraffic(300, 0);
    checkOutput("cnt_sat", underrun_cnt, 255);
    coef_pending = '{8'd1, 8'd1, 8'd1};
    runTraffic(4, 0);
    checkOutput("cnt_clear", underrun_cnt, 0);
`endif

    runTraffic(20, 0);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
